// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority bit decisions
// and a BREAK state that holds off start detection while the line stays low.
module uart_rx #(
    parameter int DIV = 651,
    parameter int OVS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int         TW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [3:0] SAMP_LAST = 4'(OVS - 1);
    localparam logic [3:0] SAMP_MID  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [TW-1:0]   r_tick_cnt;
    logic [3:0]      r_samp;
    logic [2:0]      r_bitidx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_ferr;
    logic            r_s6;
    logic            r_s7;
    logic            w_tick;
    logic            w_maj;

    assign w_tick       = (r_tick_cnt == TW'(DIV - 1));
    assign w_maj        = (r_s6 & r_s7) | (r_s6 & r_sync2) | (r_s7 & r_sync2);
    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr;
    assign rx_busy      = (r_state != S_IDLE);

    // Two-flop synchronizer for the asynchronous serial input (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RxD;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running oversample tick generator, 0..DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Capture the first two of the three majority samples (counts 6 and 7).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s6 <= 1'b1;
            r_s7 <= 1'b1;
        end else if (w_tick) begin
            if (r_samp == 4'd6) r_s6 <= r_sync2;
            if (r_samp == 4'd7) r_s7 <= r_sync2;
        end
    end

    // Receive FSM: sample counter, bit index, shift register and output pulses.
    // Every state transition clears the sample counter; otherwise it advances per tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_samp   <= '0;
            r_bitidx <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (w_tick) begin
                r_samp <= r_samp + 4'd1;
                case (r_state)
                    S_IDLE: begin
                        if (!r_sync2) begin
                            r_state <= S_START;
                            r_samp  <= '0;
                        end
                    end
                    S_START: begin
                        if (r_samp == SAMP_MID && w_maj) begin
                            r_state <= S_IDLE;
                            r_samp  <= '0;
                        end else if (r_samp == SAMP_LAST) begin
                            r_state  <= S_DATA;
                            r_samp   <= '0;
                            r_bitidx <= '0;
                        end
                    end
                    S_DATA: begin
                        if (r_samp == SAMP_MID) begin
                            r_shift <= {w_maj, r_shift[7:1]};
                        end
                        if (r_samp == SAMP_LAST) begin
                            r_samp <= '0;
                            if (r_bitidx == 3'd7) begin
                                r_state <= S_STOP;
                            end else begin
                                r_bitidx <= r_bitidx + 3'd1;
                            end
                        end
                    end
                    S_STOP: begin
                        // Leave at mid-stop-bit so a start bit can follow immediately.
                        if (r_samp == SAMP_MID) begin
                            r_samp <= '0;
                            if (w_maj) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= S_BREAK;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (r_sync2) begin
                            r_state <= S_IDLE;
                            r_samp  <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_samp  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard of expected receive events,
// checked whenever the receiver pulses rx_valid or rx_frame_err.
module tb_uart_rx;

    localparam int DIV = 8;
    localparam int BIT = DIV * 16;

    logic       clk;
    logic       rst;
    logic       RxD;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } ev_t;

    ev_t        sb[$];
    logic [7:0] last_good;
    int         n_checks;
    int         n_errors;

    uart_rx #(.DIV(DIV), .OVS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .RxD          (RxD),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge and score any pulse.
    task automatic step();
        ev_t ev;
        @(negedge clk);
        if (rx_valid === 1'b1 || rx_frame_err === 1'b1) begin
            chk("pulse_exclusive", {31'b0, rx_valid & rx_frame_err}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'b0, rx_valid, rx_frame_err}, 32'd0);
            end else begin
                ev = sb.pop_front();
                chk("pulse_frame_err", {31'b0, rx_frame_err}, {31'b0, ev.err});
                chk("pulse_valid", {31'b0, rx_valid}, {31'b0, ~ev.err});
                chk("rx_data", {24'b0, rx_data}, {24'b0, ev.data});
            end
        end
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) step();
    endtask

    // Drive frame cycles [from, to) of a 10-bit 8N1 frame; to==0 means to the end.
    task automatic frame(input logic [7:0] d, input int per, input logic stopb,
                         input int from, input int to);
        logic [9:0] bits;
        int cnt;
        bits = {stopb, d, 1'b0};
        cnt  = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < per; c++) begin
                if (to > 0 && cnt >= to) return;
                if (cnt >= from) begin
                    RxD = bits[b];
                    step();
                end
                cnt++;
            end
        end
    endtask

    task automatic expect_good(input logic [7:0] d);
        sb.push_back('{err: 1'b0, data: d});
        last_good = d;
    endtask

    task automatic expect_err();
        sb.push_back('{err: 1'b1, data: last_good});
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        last_good = 8'h00;
        RxD       = 1'b1;
        rst       = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_rx_data", {24'b0, rx_data}, 32'h00);
        chk("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("reset_rx_frame_err", {31'b0, rx_frame_err}, 32'd0);
        chk("reset_rx_busy", {31'b0, rx_busy}, 32'd0);
        rst = 1'b0;
        idle(2 * BIT);

        // Single frame 0x41 with busy observed mid-frame
        expect_good(8'h41);
        frame(8'h41, BIT, 1'b1, 0, 2 * BIT);
        chk("busy_mid_frame", {31'b0, rx_busy}, 32'd1);
        frame(8'h41, BIT, 1'b1, 2 * BIT, 0);
        idle(BIT);
        chk("busy_after_frame", {31'b0, rx_busy}, 32'd0);
        chk("sb_empty_single", sb.size(), 32'd0);

        // Back-to-back frames with no idle gap
        expect_good(8'h00);
        expect_good(8'hFF);
        expect_good(8'h55);
        frame(8'h00, BIT, 1'b1, 0, 0);
        frame(8'hFF, BIT, 1'b1, 0, 0);
        frame(8'h55, BIT, 1'b1, 0, 0);
        idle(2 * BIT);
        chk("sb_empty_b2b", sb.size(), 32'd0);
        chk("rx_data_b2b", {24'b0, rx_data}, 32'h55);

        // False start: 3 ticks low
        RxD = 1'b0;
        repeat (3 * DIV) step();
        chk("busy_false_start_detect", {31'b0, rx_busy}, 32'd1);
        RxD = 1'b1;
        repeat (BIT + BIT / 4 - 3 * DIV) step();
        chk("busy_false_start_abort", {31'b0, rx_busy}, 32'd0);
        idle(BIT);
        chk("sb_empty_false_start", sb.size(), 32'd0);

        // Framing error then break of 3 frame times
        expect_err();
        frame(8'hA5, BIT, 1'b0, 0, 0);
        RxD = 1'b0;
        repeat (30 * BIT) step();
        chk("busy_in_break", {31'b0, rx_busy}, 32'd1);
        chk("rx_data_held_break", {24'b0, rx_data}, 32'h55);
        chk("sb_empty_ferr", sb.size(), 32'd0);
        idle(2 * BIT);
        chk("busy_after_break", {31'b0, rx_busy}, 32'd0);
        expect_good(8'h3C);
        frame(8'h3C, BIT, 1'b1, 0, 0);
        idle(BIT);
        chk("sb_empty_after_break", sb.size(), 32'd0);

        // Reset during data bit 4 of 0x96
        frame(8'h96, BIT, 1'b1, 0, 5 * BIT + BIT / 2);
        rst = 1'b1;
        #1;
        chk("midrst_rx_data", {24'b0, rx_data}, 32'h00);
        chk("midrst_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("midrst_rx_frame_err", {31'b0, rx_frame_err}, 32'd0);
        chk("midrst_rx_busy", {31'b0, rx_busy}, 32'd0);
        last_good = 8'h00;
        idle(BIT);
        rst = 1'b0;
        idle(BIT);
        expect_good(8'h69);
        frame(8'h69, BIT, 1'b1, 0, 0);
        idle(BIT);
        chk("rx_data_after_reset", {24'b0, rx_data}, 32'h69);
        chk("sb_empty_after_reset", sb.size(), 32'd0);

        // Baud skew: fast and slow transmitter
        expect_good(8'hC3);
        frame(8'hC3, BIT - 3, 1'b1, 0, 0);
        idle(BIT);
        chk("sb_empty_skew_fast", sb.size(), 32'd0);
        expect_good(8'hC3);
        frame(8'hC3, BIT + 3, 1'b1, 0, 0);
        idle(BIT);
        chk("sb_empty_skew_slow", sb.size(), 32'd0);
        chk("rx_data_skew", {24'b0, rx_data}, 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DIV, 651, clk cycles per oversample tick (16x oversampling; 651 gives 9600 baud from a 100 MHz clk).
REQ-002 Parameter: OVS, 16, oversample ticks per bit; fixed at 16, other values unsupported.
REQ-003 clk  input  1  single system clock (PLL output); all logic on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 RxD  input  1  serial input; asynchronous to clk; idles high.
REQ-006 rx_data  output  8  last correctly received byte; held until the next good frame.
REQ-007 rx_valid  output  1  one-clk pulse; rx_data is new and valid in the same cycle.
REQ-008 rx_frame_err  output  1  one-clk pulse; stop bit sampled low.
REQ-009 rx_busy  output  1  high in every state except IDLE.

Function
REQ-010 Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-011 RxD SHALL pass through a 2-FF synchronizer; all decisions use the synchronized value.
REQ-012 Tick generator SHALL be a free-running counter 0..DIV-1; tick is asserted for one clk when the count equals DIV-1.
REQ-013 Sample counter (4 bits, 0..15) SHALL advance only on tick, wrap 15->0, and clear on every state entry.
REQ-014 Bit decision SHALL be a 2-of-3 majority of the synchronized RxD sampled at sample counts 6, 7 and 8; the decision is taken on the tick where the count is 8.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-016 IDLE: on a tick with synced RxD=0, go to START; otherwise remain in IDLE.
REQ-017 START: if the majority at count 8 is 1, treat as a false start and return to IDLE; otherwise, on the tick at count 15, go to DATA with bit index 0.
REQ-018 DATA: the majority at count 8 is shifted into the data shift register (LSB first).
REQ-019 DATA: on the tick at count 15, the bit index increments; after index 7, go to STOP.
REQ-020 STOP, majority 1 at count 8: load rx_data from the shift register, pulse rx_valid for one clk, go to IDLE in the same cycle.
REQ-021 STOP, majority 0 at count 8: pulse rx_frame_err, leave rx_data unchanged, go to BREAK.
REQ-022 BREAK: remain until a tick with synced RxD=1, then go to IDLE; no start detection while in BREAK.
REQ-023 rx_valid and rx_frame_err SHALL never assert together; each is high for exactly one clk per frame.
REQ-024 rx_valid latency: asserted 9.5 bit times (+0..1 tick, +2 clk synchronizer) after the RxD falling edge of the start bit.
REQ-025 Exiting STOP at mid-bit SHALL allow back-to-back frames with zero idle time between the stop bit and the next start bit.
REQ-026 Receiver SHALL tolerate a baud-rate mismatch of at least ±2% between transmitter and DIV.
REQ-027 There is no flow control: a new good frame overwrites rx_data, and no overrun flag is provided.

Reset
REQ-028 While rst=1 (asynchronous assert):
- state=IDLE;
- tick and sample counters = 0;
- shift register = 0x00;
- synchronizer FFs = 1;
- rx_data=0x00, rx_valid=0, rx_frame_err=0, rx_busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no rx_valid or rx_frame_err pulse.
REQ-030 After reset release, the first falling edge of synced RxD SHALL begin a new frame normally.

Verification
REQ-031 Single frame: send 0x41 at 9600 baud (bit period 10416 clk, DIV=651) -> one rx_valid pulse, rx_data=0x41, rx_busy high from start detection until the rx_valid cycle, no rx_frame_err.
REQ-032 Back-to-back frames: send 0x00, 0xFF, 0x55 with no idle gap -> three rx_valid pulses with rx_data 0x00, 0xFF, 0x55 in order, and no rx_frame_err.
REQ-033 False start: drive RxD low for 3×651 clk, then high -> no rx_valid or rx_frame_err pulse, FSM returns to IDLE, and rx_busy drops before the expected data-bit time.
REQ-034 Framing error / break:
- send 0xA5 with stop bit=0, then hold RxD low for 3 frame times -> exactly one rx_frame_err pulse, rx_data keeps its previous value, rx_busy stays high.
- then release RxD high and send 0x3C -> rx_valid with rx_data=0x3C.
REQ-035 Reset mid-frame: assert rst during data bit 4 of 0x96 -> all outputs at reset values immediately, no pulse for 0x96; next frame 0x69 -> rx_data=0x69.
REQ-036 Baud skew: send 0xC3 at bit periods of 10208 and 10624 clk (±2%) -> rx_data=0xC3 with no rx_frame_err in both runs.
